// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM encoding, BCD limits
// and the BCD digit-pair increment helper.
package lap_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [7:0] BCD_MAX_CC = 8'h99;
  localparam logic [7:0] BCD_MAX_SS = 8'h59;
  localparam logic [7:0] BCD_MAX_MM = 8'h59;

  typedef struct packed {
    logic [7:0] mm;
    logic [7:0] ss;
    logic [7:0] cc;
  } bcd_time_t;

  // Adds one to a two-digit BCD value; the caller handles wrap at its limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/lap_stopwatch_bcd_up_counter_mod.sv
// Two-digit BCD up counter that wraps to zero after MAX_BCD and flags the wrap
// with a carry in the same cycle as the wrapping increment.
module bcd_up_counter_mod
  import lap_stopwatch_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = 8'h99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count,
  output logic       carry
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    carry   = inc && (count_q == MAX_BCD);
    count_d = count_q;
    if (clr)      count_d = '0;
    else if (inc) count_d = carry ? '0 : bcd_inc(count_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Count-up mm:ss.cc stopwatch with lap freeze, saturation at 59:59.99 and a
// BCD display word that switches between ss:cc and mm:ss.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [15:0] value,
  output logic        show_min,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t        state_q;
  logic [PW-1:0] presc_q, presc_d;
  bcd_time_t     live, lap_q, src;
  logic          overflow_q;
  logic [7:0]    cnt_cc, cnt_ss, cnt_mm;
  logic          cc_carry, ss_carry, mm_carry;
  logic          counting, tick, at_max, sat, cnt_clr, cc_inc;
  logic          clr_win, start_win, lap_win;

  // Only the highest-priority pulse of a simultaneous group is acted upon.
  assign clr_win   = btn_clear;
  assign start_win = btn_start && !btn_clear;
  assign lap_win   = btn_lap && !btn_start && !btn_clear;

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PRESC_LAST);
  assign live     = {cnt_mm, cnt_ss, cnt_cc};
  assign at_max   = (live == {BCD_MAX_MM, BCD_MAX_SS, BCD_MAX_CC});
  assign cnt_clr  = (state_q == PAUSE) && clr_win;
  assign cc_inc   = tick && !at_max;
  // A tick at the top value (or any cascade reaching past minutes) saturates.
  assign sat      = tick && (at_max || mm_carry);

  always_comb begin
    presc_d = presc_q;
    case (state_q)
      IDLE:    presc_d = '0;
      RUN,
      LAP:     presc_d = tick ? '0 : presc_q + PW'(1);
      PAUSE:   presc_d = cnt_clr ? '0 : presc_q;
      default: presc_d = '0;
    endcase
  end

  bcd_up_counter_mod #(.MAX_BCD(BCD_MAX_CC)) u_cnt_cc (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc(cc_inc),
    .count(cnt_cc), .carry(cc_carry)
  );
  bcd_up_counter_mod #(.MAX_BCD(BCD_MAX_SS)) u_cnt_ss (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc(cc_carry),
    .count(cnt_ss), .carry(ss_carry)
  );
  bcd_up_counter_mod #(.MAX_BCD(BCD_MAX_MM)) u_cnt_mm (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc(ss_carry),
    .count(cnt_mm), .carry(mm_carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      lap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      if (sat) begin
        state_q    <= PAUSE;
        overflow_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (start_win) state_q <= RUN;
          RUN: begin
            if (start_win) state_q <= PAUSE;
            else if (lap_win) begin
              state_q <= LAP;
              lap_q   <= live;
            end
          end
          LAP: begin
            if (start_win)    state_q <= PAUSE;
            else if (lap_win) state_q <= RUN;
          end
          PAUSE: begin
            if (clr_win) begin
              state_q    <= IDLE;
              overflow_q <= 1'b0;
            end else if (start_win && !overflow_q) begin
              state_q <= RUN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign src        = (state_q == LAP) ? lap_q : live;
  assign show_min   = (src.mm != 8'h00);
  assign value      = show_min ? {src.mm, src.ss} : {src.ss, src.cc};
  assign running    = counting;
  assign lap_active = (state_q == LAP);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch: a centisecond-integer reference model
// queues the expected outputs each clock and a monitor compares them.
module tb_lap_stopwatch;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MAX_CS  = 59 * 6000 + 59 * 100 + 99;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_LAP   = 2;
  localparam int M_PAUSE = 3;

  typedef struct packed {
    logic [15:0] value;
    logic        show_min;
    logic        running;
    logic        lap_active;
    logic        overflow;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        btn_start, btn_lap, btn_clear;
  logic [15:0] value;
  logic        show_min, running, lap_active, overflow;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  int m_state, m_presc, m_cs, m_lap;
  bit m_ovf;

  logic [7:0] pre_mm, pre_ss, pre_cc;

  lap_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .value(value), .show_min(show_min), .running(running),
    .lap_active(lap_active), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] bcd2(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int src, mm, ss, cc;
    src = (m_state == M_LAP) ? m_lap : m_cs;
    mm  = src / 6000;
    ss  = (src / 100) % 60;
    cc  = src % 100;
    e.show_min   = (mm != 0);
    e.value      = (mm != 0) ? {bcd2(mm), bcd2(ss)} : {bcd2(ss), bcd2(cc)};
    e.running    = (m_state == M_RUN) || (m_state == M_LAP);
    e.lap_active = (m_state == M_LAP);
    e.overflow   = m_ovf;
    return e;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_presc = 0;
    m_cs    = 0;
    m_lap   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit l, input bit c);
    bit ws, wl, active, tk, sat;
    int ns, np, old_cs;
    ws     = s && !c;
    wl     = l && !s && !c;
    active = (m_state == M_RUN) || (m_state == M_LAP);
    tk     = active && (m_presc == DIV - 1);
    sat    = tk && (m_cs == MAX_CS);
    old_cs = m_cs;
    ns     = m_state;
    if (m_state == M_IDLE)     np = 0;
    else if (active)           np = tk ? 0 : m_presc + 1;
    else                       np = c ? 0 : m_presc;
    if (tk && !sat) m_cs = m_cs + 1;
    if (sat) begin
      ns    = M_PAUSE;
      m_ovf = 1'b1;
    end else if (m_state == M_IDLE) begin
      if (ws) ns = M_RUN;
    end else if (m_state == M_RUN) begin
      if (ws) ns = M_PAUSE;
      else if (wl) begin
        ns    = M_LAP;
        m_lap = old_cs;
      end
    end else if (m_state == M_LAP) begin
      if (ws)      ns = M_PAUSE;
      else if (wl) ns = M_RUN;
    end else begin
      if (c) begin
        ns    = M_IDLE;
        m_cs  = 0;
        m_ovf = 1'b0;
      end else if (ws && !m_ovf) begin
        ns = M_RUN;
      end
    end
    m_state = ns;
    m_presc = np;
  endtask

  task automatic step(input bit s, input bit l, input bit c);
    btn_start = s;
    btn_lap   = l;
    btn_clear = c;
    @(posedge clk);
    model_step(s, l, c);
    exp_q.push_back(model_out());
    @(negedge clk);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Loads the live count while IDLE, so long runs need not be clocked through.
  task automatic preload(input int cs);
    pre_mm = bcd2(cs / 6000);
    pre_ss = bcd2((cs / 100) % 60);
    pre_cc = bcd2(cs % 100);
    force dut.u_cnt_mm.count_q = pre_mm;
    force dut.u_cnt_ss.count_q = pre_ss;
    force dut.u_cnt_cc.count_q = pre_cc;
    m_cs = cs;
    step(1'b0, 1'b0, 1'b0);
    release dut.u_cnt_mm.count_q;
    release dut.u_cnt_ss.count_q;
    release dut.u_cnt_cc.count_q;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check16("value", value, e.value);
        check1("show_min", show_min, e.show_min);
        check1("running", running, e.running);
        check1("lap_active", lap_active, e.lap_active);
        check1("overflow", overflow, e.overflow);
      end
    end
  end

  initial begin : driver
    int r;
    reset_n   = 1'b0;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check16("rst_value", value, 16'h0000);
    check1("rst_running", running, 1'b0);
    check1("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;

    // Mid-run asynchronous reset at 00:03.07
    step(1'b1, 1'b0, 1'b0);
    idle(3070);
    check16("t1_value_before_reset", value, 16'h0307);
    reset_n = 1'b0;
    #1;
    model_reset();
    check16("t1_rst_value", value, 16'h0000);
    check1("t1_rst_running", running, 1'b0);
    check1("t1_rst_show_min", show_min, 1'b0);
    check1("t1_rst_lap_active", lap_active, 1'b0);
    check1("t1_rst_overflow", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    check1("t1_idle_after_release", running, 1'b0);

    // Plain counting
    step(1'b1, 1'b0, 1'b0);
    idle(1230);
    check16("t2_value", value, 16'h0123);
    check1("t2_show_min", show_min, 1'b0);
    check1("t2_running", running, 1'b1);

    // Lap freeze and release
    idle(3770);
    step(1'b0, 1'b1, 1'b0);
    check1("t3_lap_active", lap_active, 1'b1);
    check16("t3_lap_value", value, 16'h0500);
    idle(1998);
    check16("t3_frozen_value", value, 16'h0500);
    step(1'b0, 1'b1, 1'b0);
    check16("t3_released_value", value, 16'h0700);
    check1("t3_released_lap", lap_active, 1'b0);

    // Pause keeps the prescaler fraction
    idle(3004);
    step(1'b1, 1'b0, 1'b0);
    idle(500);
    check16("t4_paused_value", value, 16'h1000);
    check1("t4_paused_running", running, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(4);
    check16("t4_before_tick", value, 16'h1000);
    idle(1);
    check16("t4_resumed_tick", value, 16'h1001);
    step(1'b0, 1'b0, 1'b1);
    check16("t4_clear_in_run", value, 16'h1001);
    check1("t4_clear_in_run_running", running, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check16("t4_cleared_value", value, 16'h0000);

    // Minute rollover and saturation
    preload(5990);
    step(1'b1, 1'b0, 1'b0);
    idle(100);
    check16("t5_minute_value", value, 16'h0100);
    check1("t5_minute_show_min", show_min, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    preload(359990);
    step(1'b1, 1'b0, 1'b0);
    idle(100);
    check16("t5_sat_value", value, 16'h5959);
    check1("t5_sat_overflow", overflow, 1'b1);
    check1("t5_sat_running", running, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check1("t5_start_ignored", running, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check1("t5_clear_overflow", overflow, 1'b0);
    check16("t5_clear_value", value, 16'h0000);
    preload(359995);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(49);
    check1("t5_lap_sat_released", lap_active, 1'b0);
    check1("t5_lap_sat_overflow", overflow, 1'b1);
    check16("t5_lap_sat_value", value, 16'h5959);
    step(1'b0, 1'b0, 1'b1);

    // Simultaneous pulses
    step(1'b1, 1'b0, 1'b0);
    idle(25);
    step(1'b1, 1'b1, 1'b0);
    check1("t6_start_lap_running", running, 1'b0);
    check1("t6_start_lap_lap", lap_active, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check1("t6_clear_start_running", running, 1'b0);
    check16("t6_clear_start_value", value, 16'h0000);

    // Randomised single-button traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      step(r < 3, (r >= 3) && (r < 6), (r >= 6) && (r < 8));
    end

    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
